branch_sequencer: RTL and testbench

- Controls conditional and unconditional jumps for the single-cycle-fetch datapath.
- Holds the architectural flag register {O,S,C,Z}, written from the ALU.
- Accepts one branch request at a time from decode and stalls while an in-flight instruction still owes a flag write.
- Resolves the jump against the stored flags, drives the PC mux select and flushes the fetched-but-wrong instructions with a programmable flush counter.

---
 rtl/branch_sequencer_pkg.sv | 45 ++++
 rtl/branch_sequencer_if.sv | 28 ++
 rtl/branch_cond_eval.sv | 39 +++
 rtl/branch_sequencer.sv | 137 +++++++++++++
 tb/tb_branch_sequencer.sv | 241 ++++++++++++++++++++++++
 5 files changed

// File: rtl/branch_sequencer_pkg.sv
// Shared codes, widths and payload types for the branch sequencer.
package branch_sequencer_pkg;

  localparam int unsigned OP_W    = 3;
  localparam int unsigned COND_W  = 3;
  localparam int unsigned FLAG_W  = 4;
  localparam int unsigned CNT_W   = 4;
  localparam int unsigned STATE_W = 2;

  // Branch operation codes; 101/110 decode as none.
  localparam logic [OP_W-1:0] OP_JF   = 3'b000;
  localparam logic [OP_W-1:0] OP_JT   = 3'b001;
  localparam logic [OP_W-1:0] OP_J    = 3'b010;
  localparam logic [OP_W-1:0] OP_JAL  = 3'b011;
  localparam logic [OP_W-1:0] OP_JR   = 3'b100;
  localparam logic [OP_W-1:0] OP_NONE = 3'b111;

  localparam logic [COND_W-1:0] COND_TRUE    = 3'b000;
  localparam logic [COND_W-1:0] COND_NEG     = 3'b001;
  localparam logic [COND_W-1:0] COND_ZERO    = 3'b010;
  localparam logic [COND_W-1:0] COND_CARRY   = 3'b100;
  localparam logic [COND_W-1:0] COND_NEGZERO = 3'b101;
  localparam logic [COND_W-1:0] COND_OVF     = 3'b111;

  localparam int unsigned FLAG_O = 3;
  localparam int unsigned FLAG_S = 2;
  localparam int unsigned FLAG_C = 1;
  localparam int unsigned FLAG_Z = 0;

  localparam logic [STATE_W-1:0] ST_IDLE  = 2'd0;
  localparam logic [STATE_W-1:0] ST_WAIT  = 2'd1;
  localparam logic [STATE_W-1:0] ST_EVAL  = 2'd2;
  localparam logic [STATE_W-1:0] ST_FLUSH = 2'd3;

  typedef struct packed {
    logic [OP_W-1:0]   op;
    logic [COND_W-1:0] cond;
  } br_req_t;

  // Only jf/jt depend on flags and therefore on pending flag writes.
  function automatic logic is_cond_op(input logic [OP_W-1:0] op);
    return (op == OP_JF) || (op == OP_JT);
  endfunction

endpackage

// File: rtl/branch_sequencer_if.sv
// Decode/ALU <-> branch sequencer handshake and control bundle.
interface branch_sequencer_if;
  import branch_sequencer_pkg::*;

  logic [FLAG_W-1:0] alu_flags_i;
  logic              flag_we_i;
  logic              flag_pend_i;
  logic              br_valid_i;
  logic              br_ready_o;
  logic [OP_W-1:0]   op_tf_i;
  logic [COND_W-1:0] cond_i;
  logic              stall_o;
  logic              taken_o;
  logic              pc_sel_o;
  logic              flush_o;
  logic [FLAG_W-1:0] flags_o;

  modport master (
    output alu_flags_i, flag_we_i, flag_pend_i, br_valid_i, op_tf_i, cond_i,
    input  br_ready_o, stall_o, taken_o, pc_sel_o, flush_o, flags_o
  );

  modport slave (
    input  alu_flags_i, flag_we_i, flag_pend_i, br_valid_i, op_tf_i, cond_i,
    output br_ready_o, stall_o, taken_o, pc_sel_o, flush_o, flags_o
  );

endinterface

// File: rtl/branch_cond_eval.sv
// Combinational jump resolution from operation, condition and flags.
module branch_cond_eval
  import branch_sequencer_pkg::*;
(
  input  logic [OP_W-1:0]   op_i,
  input  logic [COND_W-1:0] cond_i,
  input  logic [FLAG_W-1:0] flags_i,
  output logic              taken_c_o
);

  logic term;
  logic defined;

  always_comb begin
    term    = 1'b0;
    defined = 1'b1;
    case (cond_i)
      COND_TRUE:    term = 1'b1;
      COND_NEG:     term = flags_i[FLAG_S];
      COND_ZERO:    term = flags_i[FLAG_Z];
      COND_CARRY:   term = flags_i[FLAG_C];
      COND_NEGZERO: term = flags_i[FLAG_S] & flags_i[FLAG_Z];
      COND_OVF:     term = flags_i[FLAG_O];
      default:      defined = 1'b0;
    endcase
  end

  // Undefined conditions never jump, whichever polarity is requested.
  always_comb begin
    taken_c_o = 1'b0;
    case (op_i)
      OP_JF:               taken_c_o = defined & ~term;
      OP_JT:               taken_c_o = defined & term;
      OP_J, OP_JAL, OP_JR: taken_c_o = 1'b1;
      default:             taken_c_o = 1'b0;
    endcase
  end

endmodule

// File: rtl/branch_sequencer.sv
// Branch sequencer: flag register, hazard wait, jump resolution and flush.
// Optional saturating statistics counters when BRANCH_STATS_EN is defined.
module branch_sequencer
  import branch_sequencer_pkg::*;
#(
  parameter int unsigned FLUSH_CYCLES = 2
`ifdef BRANCH_STATS_EN
  , parameter int unsigned STAT_W     = 16
`endif
) (
  input  logic               clk,
  input  logic               reset,
  branch_sequencer_if.slave  bus
`ifdef BRANCH_STATS_EN
  , output logic [STAT_W-1:0] stat_total_o
  , output logic [STAT_W-1:0] stat_taken_o
`endif
);

  logic [STATE_W-1:0] state_q, state_d;
  br_req_t            req_q, req_d;
  logic [FLAG_W-1:0]  flags_q, flags_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic               ready_q, ready_d;
  logic               stall_q, stall_d;
  logic               taken_q, taken_d;
  logic               pc_sel_q, pc_sel_d;
  logic               flush_q, flush_d;
  logic               eval_taken_c;

  // Resolved on the values EVAL will hold so TAKEN can leave a flop.
  branch_cond_eval u_cond_eval (
    .op_i      (req_d.op),
    .cond_i    (req_d.cond),
    .flags_i   (flags_d),
    .taken_c_o (eval_taken_c)
  );

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q  <= ST_IDLE;
      req_q    <= '0;
      flags_q  <= '0;
      cnt_q    <= '0;
      ready_q  <= 1'b1;
      stall_q  <= 1'b0;
      taken_q  <= 1'b0;
      pc_sel_q <= 1'b1;
      flush_q  <= 1'b0;
    end else begin
      state_q  <= state_d;
      req_q    <= req_d;
      flags_q  <= flags_d;
      cnt_q    <= cnt_d;
      ready_q  <= ready_d;
      stall_q  <= stall_d;
      taken_q  <= taken_d;
      pc_sel_q <= pc_sel_d;
      flush_q  <= flush_d;
    end
  end

  always_comb begin
    state_d = state_q;
    req_d   = req_q;
    cnt_d   = cnt_q;
    flags_d = bus.flag_we_i ? bus.alu_flags_i : flags_q;

    case (state_q)
      ST_IDLE: begin
        if (bus.br_valid_i) begin
          req_d.op   = bus.op_tf_i;
          req_d.cond = bus.cond_i;
          state_d    = (is_cond_op(bus.op_tf_i) && bus.flag_pend_i) ? ST_WAIT : ST_EVAL;
        end
      end
      ST_WAIT: begin
        if (!bus.flag_pend_i) state_d = ST_EVAL;
      end
      ST_EVAL: begin
        if (taken_q) begin
          state_d = ST_FLUSH;
          cnt_d   = CNT_W'(FLUSH_CYCLES);
        end else begin
          state_d = ST_IDLE;
        end
      end
      ST_FLUSH: begin
        cnt_d = cnt_q - CNT_W'(1);
        if (cnt_q == CNT_W'(1)) state_d = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase

    ready_d  = (state_d == ST_IDLE);
    stall_d  = (state_d == ST_WAIT) || (state_d == ST_EVAL);
    taken_d  = (state_d == ST_EVAL) && eval_taken_c;
    pc_sel_d = ~taken_d;
    flush_d  = (state_d == ST_FLUSH);
  end

  assign bus.br_ready_o = ready_q;
  assign bus.stall_o    = stall_q;
  assign bus.taken_o    = taken_q;
  assign bus.pc_sel_o   = pc_sel_q;
  assign bus.flush_o    = flush_q;
  assign bus.flags_o    = flags_q;

`ifdef BRANCH_STATS_EN
  logic [STAT_W-1:0] total_q, total_d;
  logic [STAT_W-1:0] ntaken_q, ntaken_d;

  always_ff @(posedge clk) begin
    if (reset) begin
      total_q  <= '0;
      ntaken_q <= '0;
    end else begin
      total_q  <= total_d;
      ntaken_q <= ntaken_d;
    end
  end

  // Both counters saturate at all-ones.
  always_comb begin
    total_d  = total_q;
    ntaken_d = ntaken_q;
    if (state_q == ST_EVAL) begin
      if (total_q != '1) total_d = total_q + STAT_W'(1);
      if (taken_q && (ntaken_q != '1)) ntaken_d = ntaken_q + STAT_W'(1);
    end
  end

  assign stat_total_o = total_q;
  assign stat_taken_o = ntaken_q;
`endif

endmodule

// File: tb/tb_branch_sequencer.sv
// Directed bench: two sequencers (flush 2 and 4) share stimulus and are
// checked every cycle against a queue-free behavioural model.
module tb_branch_sequencer;
  import branch_sequencer_pkg::*;

  localparam int unsigned FC_A = 2;
  localparam int unsigned FC_B = 4;

  logic       clk = 1'b0;
  logic       reset;
  logic [3:0] alu;
  logic       we, pend, valid;
  logic [2:0] op, cond;
  bit         chk_en = 1'b0;
  int         errors = 0;
  int         checks = 0;

  always #5 clk = ~clk;

  branch_sequencer_if ifa ();
  branch_sequencer_if ifb ();

  assign ifa.alu_flags_i = alu;   assign ifb.alu_flags_i = alu;
  assign ifa.flag_we_i   = we;    assign ifb.flag_we_i   = we;
  assign ifa.flag_pend_i = pend;  assign ifb.flag_pend_i = pend;
  assign ifa.br_valid_i  = valid; assign ifb.br_valid_i  = valid;
  assign ifa.op_tf_i     = op;    assign ifb.op_tf_i     = op;
  assign ifa.cond_i      = cond;  assign ifb.cond_i      = cond;

`ifdef BRANCH_STATS_EN
  logic [15:0] sa_tot, sa_tk, sb_tot, sb_tk;
`endif

  branch_sequencer #(.FLUSH_CYCLES(FC_A)) u_a (
    .clk(clk), .reset(reset), .bus(ifa)
`ifdef BRANCH_STATS_EN
    , .stat_total_o(sa_tot), .stat_taken_o(sa_tk)
`endif
  );

  branch_sequencer #(.FLUSH_CYCLES(FC_B)) u_b (
    .clk(clk), .reset(reset), .bus(ifb)
`ifdef BRANCH_STATS_EN
    , .stat_total_o(sb_tot), .stat_taken_o(sb_tk)
`endif
  );

  // ---------------- behavioural model ----------------
  logic [3:0] m_flags [2];
  bit         m_wait  [2];
  bit         m_eval  [2];
  bit         m_tk    [2];
  int         m_fl    [2];
  logic [2:0] m_op    [2];
  logic [2:0] m_cond  [2];
  int         m_tot   [2];
  int         m_ntk   [2];

  function automatic bit resolve(input logic [2:0] o, input logic [2:0] c, input logic [3:0] f);
    bit t;
    if (o == 3'd2 || o == 3'd3 || o == 3'd4) return 1'b1;
    if (o > 3'd1) return 1'b0;
    case (c)
      3'd0: t = 1'b1;
      3'd1: t = f[2];
      3'd2: t = f[0];
      3'd4: t = f[1];
      3'd5: t = f[2] & f[0];
      3'd7: t = f[3];
      default: return 1'b0;
    endcase
    return (o == 3'd1) ? t : !t;
  endfunction

  always @(posedge clk) begin
    for (int i = 0; i < 2; i++) begin
      if (reset) begin
        m_flags[i] = '0; m_wait[i] = 0; m_eval[i] = 0; m_tk[i] = 0; m_fl[i] = 0;
        m_op[i] = '0; m_cond[i] = '0; m_tot[i] = 0; m_ntk[i] = 0;
      end else begin
        if (m_eval[i]) begin
          if (m_tot[i] < 65535) m_tot[i]++;
          if (m_tk[i] && m_ntk[i] < 65535) m_ntk[i]++;
          m_eval[i] = 0;
          if (m_tk[i]) m_fl[i] = (i == 0) ? int'(FC_A) : int'(FC_B);
        end else if (m_fl[i] > 0) begin
          m_fl[i]--;
        end else if (m_wait[i]) begin
          if (!pend) begin m_wait[i] = 0; m_eval[i] = 1; end
        end else if (valid) begin
          m_op[i] = op; m_cond[i] = cond;
          if (op <= 3'd1 && pend) m_wait[i] = 1; else m_eval[i] = 1;
        end
        if (we) m_flags[i] = alu;
        m_tk[i] = m_eval[i] && resolve(m_op[i], m_cond[i], m_flags[i]);
      end
    end
  end

  task automatic chk(input string name, input int inst, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s inst=%0d t=%0t got=%0h want=%0h", name, inst, $time, got, exp);
    end
  endtask

  task automatic cmp_inst(input int i, input logic rdy, input logic stl, input logic tk,
                          input logic pcs, input logic fl, input logic [3:0] flg);
    bit busy;
    busy = m_wait[i] || m_eval[i] || (m_fl[i] > 0);
    chk("ready",  i, 32'(rdy), 32'(!busy));
    chk("stall",  i, 32'(stl), 32'(m_wait[i] || m_eval[i]));
    chk("taken",  i, 32'(tk),  32'(m_eval[i] && m_tk[i]));
    chk("pc_sel", i, 32'(pcs), 32'(!(m_eval[i] && m_tk[i])));
    chk("flush",  i, 32'(fl),  32'(m_fl[i] > 0));
    chk("flags",  i, 32'(flg), 32'(m_flags[i]));
  endtask

  always @(negedge clk) begin
    if (chk_en) begin
      cmp_inst(0, ifa.br_ready_o, ifa.stall_o, ifa.taken_o, ifa.pc_sel_o, ifa.flush_o, ifa.flags_o);
      cmp_inst(1, ifb.br_ready_o, ifb.stall_o, ifb.taken_o, ifb.pc_sel_o, ifb.flush_o, ifb.flags_o);
`ifdef BRANCH_STATS_EN
      chk("stat_total", 0, 32'(sa_tot), 32'(m_tot[0]));
      chk("stat_taken", 0, 32'(sa_tk),  32'(m_ntk[0]));
      chk("stat_total", 1, 32'(sb_tot), 32'(m_tot[1]));
      chk("stat_taken", 1, 32'(sb_tk),  32'(m_ntk[1]));
`endif
    end
  end

  // ---------------- stimulus ----------------
  task automatic tick();
    @(posedge clk);
    #2;
  endtask

  task automatic idle(input int n);
    valid = 1'b0; we = 1'b0;
    repeat (n) tick();
  endtask

  task automatic issue(input logic [2:0] o, input logic [2:0] c);
    valid = 1'b1; op = o; cond = c;
    tick();
    valid = 1'b0; op = 3'b111;
  endtask

  initial begin
    reset = 1'b1; alu = '0; we = 1'b0; pend = 1'b0; valid = 1'b0; op = 3'b111; cond = '0;
    tick(); tick();
    reset = 1'b0;
    chk_en = 1'b1;
    chk("rst_ready",  0, 32'(ifa.br_ready_o), 32'd1);
    chk("rst_pc_sel", 0, 32'(ifa.pc_sel_o),   32'd1);
    chk("rst_flush",  0, 32'(ifa.flush_o),    32'd0);
    chk("rst_flags",  0, 32'(ifa.flags_o),    32'd0);

    // 1: jt.zero, Z=1, no hazard
    we = 1'b1; alu = 4'b0001; tick(); we = 1'b0;
    issue(3'b001, 3'b010);
    chk("t1_taken",  0, 32'(ifa.taken_o),  32'd1);
    chk("t1_pc_sel", 0, 32'(ifa.pc_sel_o), 32'd0);
    tick(); chk("t1_flush1", 0, 32'(ifa.flush_o), 32'd1);
    tick(); chk("t1_flush2", 0, 32'(ifa.flush_o), 32'd1);
    tick(); chk("t1_flush_end", 0, 32'(ifa.flush_o), 32'd0);
    chk("t1_ready", 0, 32'(ifa.br_ready_o), 32'd1);
    idle(6);

    // 2: jf.carry with C=1 -> not taken
    we = 1'b1; alu = 4'b0010; tick(); we = 1'b0;
    issue(3'b000, 3'b100);
    chk("t2_taken",  0, 32'(ifa.taken_o),  32'd0);
    chk("t2_pc_sel", 0, 32'(ifa.pc_sel_o), 32'd1);
    chk("t2_stall",  0, 32'(ifa.stall_o),  32'd1);
    tick(); chk("t2_ready", 0, 32'(ifa.br_ready_o), 32'd1);
    chk("t2_flush", 0, 32'(ifa.flush_o), 32'd0);
    idle(6);

    // 3: jt.neg behind a pending flag write
    pend = 1'b1;
    issue(3'b001, 3'b001);
    chk("t3_stall_w1", 0, 32'(ifa.stall_o), 32'd1);
    tick(); chk("t3_stall_w2", 0, 32'(ifa.stall_o), 32'd1);
    tick(); chk("t3_stall_w3", 0, 32'(ifa.stall_o), 32'd1);
    chk("t3_no_taken", 0, 32'(ifa.taken_o), 32'd0);
    pend = 1'b0; we = 1'b1; alu = 4'b0100;
    tick(); we = 1'b0;
    chk("t3_taken", 0, 32'(ifa.taken_o), 32'd1);
    chk("t3_flags", 0, 32'(ifa.flags_o), 32'h4);
    chk("t3_stall_eval", 0, 32'(ifa.stall_o), 32'd1);
    idle(8);

    // 4: jal ignores the hazard; flag write during EVAL lands afterwards
    pend = 1'b1;
    issue(3'b011, 3'b000);
    chk("t4_taken", 0, 32'(ifa.taken_o), 32'd1);
    pend = 1'b0; we = 1'b1; alu = 4'b1111;
    tick(); we = 1'b0;
    chk("t4_flags", 0, 32'(ifa.flags_o), 32'hf);
    chk("t4_flush", 0, 32'(ifa.flush_o), 32'd1);
    idle(8);

    // 5: undefined condition and a none-class op
    issue(3'b001, 3'b011);
    chk("t5a_taken", 0, 32'(ifa.taken_o), 32'd0);
    tick(); chk("t5a_flush", 0, 32'(ifa.flush_o), 32'd0);
    issue(3'b110, 3'b000);
    chk("t5b_taken", 0, 32'(ifa.taken_o), 32'd0);
    chk("t5b_stall", 0, 32'(ifa.stall_o), 32'd1);
    tick(); chk("t5b_flush", 0, 32'(ifa.flush_o), 32'd0);
    idle(4);

    // 7: request held while busy, re-accepted at the earliest slot
    valid = 1'b1; op = 3'b010; cond = 3'b000;
    repeat (14) tick();
    idle(8);

    // 6: reset in the second flush cycle of the 4-cycle instance
    issue(3'b010, 3'b000);
    tick(); chk("t6_flush1", 1, 32'(ifb.flush_o), 32'd1);
    tick(); chk("t6_flush2", 1, 32'(ifb.flush_o), 32'd1);
    reset = 1'b1;
    tick();
    reset = 1'b0;
    chk("t6_flush", 1, 32'(ifb.flush_o),    32'd0);
    chk("t6_flags", 1, 32'(ifb.flags_o),    32'd0);
    chk("t6_ready", 1, 32'(ifb.br_ready_o), 32'd1);
    chk("t6_taken", 1, 32'(ifb.taken_o),    32'd0);
`ifdef BRANCH_STATS_EN
    chk("t6_stat_total", 1, 32'(sb_tot), 32'd0);
    chk("t6_stat_taken", 1, 32'(sb_tk),  32'd0);
`endif
    idle(4);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
